// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, state encoding and defaults for the bus hub
package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_MW = 4;

    // Device index width; covers up to 16 slave ports.
    localparam int SEL_W = 4;

    localparam logic [BUS_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } hub_state_t;

endpackage

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - base/mask window decoder, lowest matching index wins
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int N_DEVICES = 2
) (
    input  logic [BUS_AW-1:0]           address,
    input  logic [N_DEVICES*BUS_AW-1:0] dev_base,
    input  logic [N_DEVICES*BUS_AW-1:0] dev_mask,
    output logic                        hit,
    output logic [SEL_W-1:0]            sel,
    output logic [BUS_AW-1:0]           offset
);

    // Scan from the highest index down so a lower-index match overwrites it.
    always_comb begin
        hit    = 1'b0;
        sel    = '0;
        offset = '0;
        for (int i = N_DEVICES - 1; i >= 0; i--) begin
            if ((address & ~dev_mask[BUS_AW*i +: BUS_AW]) == dev_base[BUS_AW*i +: BUS_AW]) begin
                hit    = 1'b1;
                sel    = i[SEL_W-1:0];
                offset = address & dev_mask[BUS_AW*i +: BUS_AW];
            end
        end
    end

endmodule

// File: rtl/bus_hub_n.sv
// rtl/bus_hub_n.sv - one host to N memory-mapped slaves; optional watchdog via BUS_HUB_TIMEOUT_EN
module bus_hub_n
    import bus_pkg::*;
#(
    parameter int                          N_DEVICES      = 2,
    parameter logic [N_DEVICES*BUS_AW-1:0] DEV_BASE       = {32'h1000_0000, 32'h0000_0000},
    parameter logic [N_DEVICES*BUS_AW-1:0] DEV_MASK       = {32'h0000_0FFF, 32'h0001_FFFF},
    parameter logic [BUS_DW-1:0]           ERR_RDATA      = ERR_RDATA_DEFAULT,
    parameter int                          TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BUS_AW-1:0]             host_address,
    input  logic [BUS_DW-1:0]             host_data_write,
    input  logic [BUS_MW-1:0]             host_write_mask,
    input  logic                          host_wen,
    input  logic                          host_ren,
    output logic [BUS_DW-1:0]             host_data_read,
    output logic                          host_ready,
    output logic                          host_error,
    output logic [N_DEVICES*BUS_AW-1:0]   device_address,
    output logic [N_DEVICES*BUS_DW-1:0]   device_data_write,
    output logic [N_DEVICES*BUS_MW-1:0]   device_write_mask,
    output logic [N_DEVICES-1:0]          device_wen,
    output logic [N_DEVICES-1:0]          device_ren,
    input  logic [N_DEVICES-1:0]          device_ready,
    input  logic [N_DEVICES*BUS_DW-1:0]   device_data_read
);

    if (N_DEVICES < 1 || N_DEVICES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("bus_hub_n: N_DEVICES must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    hub_state_t          state;
    logic [BUS_AW-1:0]   addr_q;
    logic [BUS_DW-1:0]   wdata_q;
    logic [BUS_MW-1:0]   mask_q;
    logic                is_write_q;
    logic [SEL_W-1:0]    sel_q;
    logic [N_DEVICES-1:0] wen_q;
    logic [N_DEVICES-1:0] ren_q;

    logic                dec_hit;
    logic [SEL_W-1:0]    dec_sel;
    logic [BUS_AW-1:0]   dec_offset;
    logic [N_DEVICES-1:0] dec_onehot;
    logic                sel_ready;
    logic [BUS_DW-1:0]   sel_rdata;

`ifdef BUS_HUB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    wait_cnt;
`endif

    bus_addr_decoder #(
        .N_DEVICES (N_DEVICES)
    ) u_decoder (
        .address  (host_address),
        .dev_base (DEV_BASE),
        .dev_mask (DEV_MASK),
        .hit      (dec_hit),
        .sel      (dec_sel),
        .offset   (dec_offset)
    );

    // One-hot strobe pattern for the decoded device.
    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < N_DEVICES; i++) begin
            if (dec_sel == i[SEL_W-1:0]) begin
                dec_onehot[i] = 1'b1;
            end
        end
    end

    // Only the latched device's ready and read data are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_DEVICES; i++) begin
            if (sel_q == i[SEL_W-1:0]) begin
                sel_ready = device_ready[i];
                sel_rdata = device_data_read[BUS_DW*i +: BUS_DW];
            end
        end
    end

    assign device_address    = {N_DEVICES{addr_q}};
    assign device_data_write = {N_DEVICES{wdata_q}};
    assign device_write_mask = {N_DEVICES{mask_q}};
    assign device_wen        = wen_q;
    assign device_ren        = ren_q;

    // Transaction FSM with registered strobes and host response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            mask_q         <= '0;
            is_write_q     <= 1'b0;
            sel_q          <= '0;
            wen_q          <= '0;
            ren_q          <= '0;
            host_data_read <= '0;
            host_ready     <= 1'b0;
            host_error     <= 1'b0;
`ifdef BUS_HUB_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            host_ready <= 1'b0;
            host_error <= 1'b0;
            wen_q      <= '0;
            ren_q      <= '0;
            case (state)
                IDLE: begin
                    if (host_wen || host_ren) begin
                        addr_q     <= dec_offset;
                        wdata_q    <= host_data_write;
                        mask_q     <= host_write_mask;
                        is_write_q <= host_wen;
                        sel_q      <= dec_sel;
                        if (dec_hit) begin
                            // A simultaneous read and write request is a write.
                            if (host_wen) begin
                                wen_q <= dec_onehot;
                            end else begin
                                ren_q <= dec_onehot;
                            end
                            state <= ACCESS;
`ifdef BUS_HUB_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else begin
                            host_ready     <= 1'b1;
                            host_error     <= 1'b1;
                            host_data_read <= ERR_RDATA;
                            state          <= RESP;
                        end
                    end
                end
                ACCESS, WAIT: begin
                    if (sel_ready) begin
                        host_ready     <= 1'b1;
                        host_data_read <= is_write_q ? '0 : sel_rdata;
                        state          <= RESP;
`ifdef BUS_HUB_TIMEOUT_EN
                    end else if (state == WAIT && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        host_ready     <= 1'b1;
                        host_error     <= 1'b1;
                        host_data_read <= ERR_RDATA;
                        state          <= RESP;
                    end else begin
                        if (state == WAIT) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        state <= WAIT;
`else
                    end else begin
                        state <= WAIT;
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_hub_n.sv
// tb/tb_bus_hub_n.sv - directed vector bench for bus_hub_n (default build)
module tb_bus_hub_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] host_address;
    logic [31:0] host_data_write;
    logic [3:0]  host_write_mask;
    logic        host_wen;
    logic        host_ren;
    logic [31:0] host_data_read;
    logic        host_ready;
    logic        host_error;
    logic [63:0] device_address;
    logic [63:0] device_data_write;
    logic [7:0]  device_write_mask;
    logic [1:0]  device_wen;
    logic [1:0]  device_ren;
    logic [1:0]  device_ready;
    logic [63:0] device_data_read;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_hub_n dut (
        .clk               (clk),
        .rst               (rst),
        .host_address      (host_address),
        .host_data_write   (host_data_write),
        .host_write_mask   (host_write_mask),
        .host_wen          (host_wen),
        .host_ren          (host_ren),
        .host_data_read    (host_data_read),
        .host_ready        (host_ready),
        .host_error        (host_error),
        .device_address    (device_address),
        .device_data_write (device_data_write),
        .device_write_mask (device_write_mask),
        .device_wen        (device_wen),
        .device_ren        (device_ren),
        .device_ready      (device_ready),
        .device_data_read  (device_data_read)
    );

    typedef struct {
        string       name;
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          dev;
        int          delay;
        bit          spur;
        logic [31:0] dev_rdata;
        bit          exp_hit;
        logic [31:0] exp_off;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          strobe_cycles;
        logic [1:0]  wen_seen;
        logic [1:0]  ren_seen;
        logic [31:0] addr_seen;
        logic [31:0] wdata_seen;
        logic [3:0]  mask_seen;
        logic [1:0]  exp_onehot;
        bit          done;
        int          lat;
        strobe_cycles = 0;
        wen_seen = '0;
        ren_seen = '0;
        addr_seen = '0;
        wdata_seen = '0;
        mask_seen = '0;
        done = 1'b0;
        lat = -1;
        exp_onehot = 2'b01 << v.dev;
        @(posedge clk) #1;
        host_address    = v.addr;
        host_data_write = v.wdata;
        host_write_mask = v.mask;
        host_wen        = v.wen;
        host_ren        = v.ren;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            device_ready = '0;
            if (v.exp_hit && cyc == 1 + v.delay) device_ready[v.dev] = 1'b1;
            if (v.spur && cyc == 3) device_ready[1 - v.dev] = 1'b1;
            device_data_read = (v.dev == 0) ? {32'h5555_AAAA, v.dev_rdata} : {v.dev_rdata, 32'h5555_AAAA};
            @(negedge clk);
            if ((device_wen | device_ren) != 2'b00) begin
                strobe_cycles++;
                wen_seen   = device_wen;
                ren_seen   = device_ren;
                addr_seen  = device_address[32*v.dev +: 32];
                wdata_seen = device_data_write[32*v.dev +: 32];
                mask_seen  = device_write_mask[4*v.dev +: 4];
            end
            if (host_ready) begin
                done = 1'b1;
                lat  = cyc;
                chk({v.name, ".error"}, 64'(host_error), 64'(v.exp_err));
                chk({v.name, ".rdata"}, 64'(host_data_read), 64'(v.exp_rdata));
            end else if (cyc < 29) begin
                @(posedge clk) #1;
            end
        end
        chk({v.name, ".ready_seen"}, 64'(done), 64'd1);
        chk({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, ".strobe_cycles"}, 64'(strobe_cycles), v.exp_hit ? 64'd1 : 64'd0);
        if (v.exp_hit) begin
            chk({v.name, ".wen"}, 64'(wen_seen), v.wen ? 64'(exp_onehot) : 64'd0);
            chk({v.name, ".ren"}, 64'(ren_seen), (!v.wen && v.ren) ? 64'(exp_onehot) : 64'd0);
            chk({v.name, ".offset"}, 64'(addr_seen), 64'(v.exp_off));
            if (v.wen) begin
                chk({v.name, ".wdata"}, 64'(wdata_seen), 64'(v.wdata));
                chk({v.name, ".mask"}, 64'(mask_seen), 64'(v.mask));
            end
        end
        @(posedge clk) #1;
        host_wen     = 1'b0;
        host_ren     = 1'b0;
        device_ready = '0;
    endtask

    initial begin
        rst              = 1'b1;
        host_address     = '0;
        host_data_write  = '0;
        host_write_mask  = '0;
        host_wen         = 1'b0;
        host_ren         = 1'b0;
        device_ready     = '0;
        device_data_read = '0;

        //         name       wen   ren   addr          wdata         mask     dev dly spur dev_rdata     hit off           rdata         err  lat
        vecs[0] = '{"rd_dev0",  1'b0, 1'b1, 32'h0000_0010, 32'h0,        4'h0,    0,  0,  0,  32'h1234_5678, 1, 32'h0000_0010, 32'h1234_5678, 1'b0, 2};
        vecs[1] = '{"wr_dev1",  1'b1, 1'b0, 32'h1000_0004, 32'hCAFE_F00D, 4'b0011, 1,  2,  0,  32'h7777_7777, 1, 32'h0000_0004, 32'h0000_0000, 1'b0, 4};
        vecs[2] = '{"rd_miss",  1'b0, 1'b1, 32'h2000_0000, 32'h0,        4'h0,    0,  0,  0,  32'h0,         0, 32'h0,         32'hDEAD_BEEF, 1'b1, 1};
        vecs[3] = '{"rd_spur",  1'b0, 1'b1, 32'h1000_0FFC, 32'h0,        4'h0,    1,  5,  1,  32'hA5A5_0001, 1, 32'h0000_0FFC, 32'hA5A5_0001, 1'b0, 7};
        vecs[4] = '{"wr_both",  1'b1, 1'b1, 32'h0001_FFFC, 32'h0102_0304, 4'b1111, 0,  1,  0,  32'h6666_6666, 1, 32'h0001_FFFC, 32'h0000_0000, 1'b0, 3};
        vecs[5] = '{"wr_edge0", 1'b1, 1'b0, 32'h0002_0000, 32'h1111_1111, 4'b0101, 0,  0,  0,  32'h0,         0, 32'h0,         32'hDEAD_BEEF, 1'b1, 1};
        vecs[6] = '{"rd_edge1", 1'b0, 1'b1, 32'h1000_1000, 32'h0,        4'h0,    0,  0,  0,  32'h0,         0, 32'h0,         32'hDEAD_BEEF, 1'b1, 1};
        vecs[7] = '{"rd_base1", 1'b0, 1'b1, 32'h1000_0000, 32'h0,        4'h0,    1,  0,  0,  32'h0BAD_CAFE, 1, 32'h0000_0000, 32'h0BAD_CAFE, 1'b0, 2};

        #12;
        chk("reset.host_ready", 64'(host_ready), 64'd0);
        chk("reset.host_error", 64'(host_error), 64'd0);
        chk("reset.host_data_read", 64'(host_data_read), 64'd0);
        chk("reset.strobes", 64'({device_wen, device_ren}), 64'd0);
        chk("reset.device_address", device_address, 64'd0);
        @(posedge clk) #1;
        rst = 1'b0;

        run_vec(vecs[0]);
        @(negedge clk);
        chk("hold.rdata", 64'(host_data_read), 64'h1234_5678);
        chk("hold.ready_low", 64'(host_ready), 64'd0);

        for (int i = 1; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Reset asserted while the hub waits on a device.
        @(posedge clk) #1;
        host_address = 32'h0000_0020;
        host_ren     = 1'b1;
        host_wen     = 1'b0;
        device_ready = '0;
        @(negedge clk);
        @(posedge clk) #1;
        chk("rst_wait.pre_ren", 64'(device_ren), 64'b01);
        @(posedge clk) #1;
        chk("rst_wait.pre_addr", 64'(device_address[31:0]), 64'h20);
        chk("rst_wait.pre_ren_low", 64'(device_ren), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_wait.strobes", 64'({device_wen, device_ren}), 64'd0);
        chk("rst_wait.host_ready", 64'(host_ready), 64'd0);
        chk("rst_wait.addr_cleared", device_address, 64'd0);
        host_ren = 1'b0;
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wait.no_phantom_ready", 64'(host_ready), 64'd0);
        end

        run_vec(vecs[7]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
